// File: rtl/fft_stream_loader_if.sv
// rtl/fft_stream_loader_if.sv - sample stream, result stream and RAM port bundle of the fft loader
interface fft_stream_loader_if #(
    parameter int LOGN = 12,
    parameter int DW   = 64
);
    logic [DW-1:0]   s_data;
    logic            s_valid;
    logic            s_ready;
    logic [2*DW-1:0] m_data;
    logic            m_valid;
    logic            m_ready;
    logic            m_last;
    logic            mem_en;
    logic            mem_we;
    logic [LOGN-1:0] mem_addr;
    logic [2*DW-1:0] mem_wdata;
    logic [2*DW-1:0] mem_rdata;

    modport master (
        input  s_data, s_valid, m_ready, mem_rdata,
        output s_ready, m_data, m_valid, m_last, mem_en, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        output s_data, s_valid, m_ready, mem_rdata,
        input  s_ready, m_data, m_valid, m_last, mem_en, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/fft_stream_loader.sv
// rtl/fft_stream_loader.sv - loads bit-reversed samples, runs the fft engine, streams results out
module fft_stream_loader #(
    parameter int LOGN = 12,
    parameter int DW   = 64,
    parameter int FCW  = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    fft_stream_loader_if.master     bus,
    output logic                    mem_grant,
    output logic                    fft_start,
    input  logic                    fft_done,
    output logic                    busy,
    output logic [FCW-1:0]          frame_cnt
);
    typedef enum logic [1:0] {LOAD, START, WAIT, UNLOAD} state_t;

    state_t          state, state_nx;
    logic            run_q;
    logic [LOGN-1:0] wcnt, rcnt, wcnt_rev;
    logic            rd_done;
    logic [2*DW-1:0] fifo_data [2];
    logic [1:0]      fifo_last;
    logic            rd_ptr, wr_ptr;
    logic [1:0]      occ;
    logic            in_flight, in_flight_last;
    logic            s_fire, m_fire, rd_issue;
    logic [2:0]      slots;

    always_comb begin
        wcnt_rev = '0;
        for (int i = 0; i < LOGN; i++) wcnt_rev[i] = wcnt[LOGN-1-i];
    end

    assign bus.m_valid = (occ != 2'd0);
    assign bus.m_data  = bus.m_valid ? fifo_data[rd_ptr] : '0;
    assign bus.m_last  = bus.m_valid & fifo_last[rd_ptr];
    assign m_fire      = bus.m_valid & bus.m_ready;
    assign busy        = !((state == LOAD) && (wcnt == '0));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= LOAD;
        else      state <= state_nx;
    end

    always_comb begin
        state_nx      = state;
        bus.s_ready   = 1'b0;
        bus.mem_en    = 1'b0;
        bus.mem_we    = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        fft_start     = 1'b0;
        mem_grant     = 1'b0;
        s_fire        = 1'b0;
        rd_issue      = 1'b0;
        // pending slots once this cycle's pop has freed its entry
        slots         = {1'b0, occ} + {2'b0, in_flight} - {2'b0, m_fire};
        case (state)
            LOAD: begin
                bus.s_ready = run_q;
                s_fire      = bus.s_valid & run_q;
                if (s_fire) begin
                    bus.mem_en    = 1'b1;
                    bus.mem_we    = 1'b1;
                    bus.mem_addr  = wcnt_rev;
                    bus.mem_wdata = {bus.s_data, {DW{1'b0}}};
                    if (&wcnt) state_nx = START;
                end
            end
            START: begin
                fft_start = 1'b1;
                mem_grant = 1'b1;
                state_nx  = WAIT;
            end
            WAIT: begin
                mem_grant = 1'b1;
                if (fft_done) state_nx = UNLOAD;
            end
            UNLOAD: begin
                if (!rd_done && (slots < 3'd2)) begin
                    rd_issue     = 1'b1;
                    bus.mem_en   = 1'b1;
                    bus.mem_addr = rcnt;
                end
                if (m_fire && bus.m_last) state_nx = LOAD;
            end
            default: state_nx = LOAD;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            run_q          <= 1'b0;
            wcnt           <= '0;
            rcnt           <= '0;
            rd_done        <= 1'b0;
            fifo_last      <= '0;
            rd_ptr         <= 1'b0;
            wr_ptr         <= 1'b0;
            occ            <= 2'd0;
            in_flight      <= 1'b0;
            in_flight_last <= 1'b0;
            frame_cnt      <= '0;
        end else begin
            run_q          <= 1'b1;
            in_flight      <= rd_issue;
            in_flight_last <= rd_issue & (&rcnt);
            occ            <= occ + {1'b0, in_flight} - {1'b0, m_fire};
            if (s_fire) wcnt <= wcnt + LOGN'(1);
            if (rd_issue) begin
                rcnt <= rcnt + LOGN'(1);
                if (&rcnt) rd_done <= 1'b1;
            end
            if (in_flight) begin
                fifo_last[wr_ptr] <= in_flight_last;
                wr_ptr            <= ~wr_ptr;
            end
            if (m_fire) rd_ptr <= ~rd_ptr;
            if (m_fire && bus.m_last) begin
                frame_cnt <= frame_cnt + FCW'(1);
                rd_done   <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (in_flight) fifo_data[wr_ptr] <= bus.mem_rdata;
    end
endmodule

// File: tb/tb_fft_stream_loader.sv
// tb/tb_fft_stream_loader.sv - directed bench with RAM/engine model and write/result scoreboards
module tb_fft_stream_loader;
    localparam int LOGN = 3;
    localparam int DW   = 64;
    localparam int FCW  = 16;
    localparam int N    = 8;

    typedef struct packed {
        logic [LOGN-1:0] addr;
        logic [127:0]    data;
    } wr_t;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic           mem_grant, fft_start, busy;
    logic           fft_done = 1'b0;
    logic [FCW-1:0] frame_cnt;

    always #5 clk = ~clk;

    fft_stream_loader_if #(.LOGN(LOGN), .DW(DW)) bus ();

    fft_stream_loader #(.LOGN(LOGN), .DW(DW), .FCW(FCW)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .mem_grant (mem_grant),
        .fft_start (fft_start),
        .fft_done  (fft_done),
        .busy      (busy),
        .frame_cnt (frame_cnt)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [LOGN-1:0] bitrev(input logic [LOGN-1:0] a);
        logic [LOGN-1:0] r;
        for (int k = 0; k < LOGN; k++) r[k] = a[LOGN-1-k];
        return r;
    endfunction

    // RAM and engine model: the engine overwrites the RAM with {seed+k, ~(seed+k)}
    logic [127:0] ram [N];
    int           eng_seed = 0;
    bit           eng_fill = 0;

    always @(posedge clk) begin
        if (eng_fill) begin
            for (int k = 0; k < N; k++) ram[k] <= {64'(eng_seed + k), ~64'(eng_seed + k)};
        end else if (bus.mem_en && !mem_grant) begin
            if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
            else            bus.mem_rdata     <= ram[bus.mem_addr];
        end
    end

    bit rdy_random = 0;
    initial begin
        bus.m_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            bus.m_ready = rdy_random ? ($urandom_range(0, 9) < 3) : 1'b1;
        end
    end

    wr_t            wexp [$];
    logic [128:0]   rexp [$];
    int             n_start = 0;
    int             reads_issued = 0;
    int             pops = 0;
    int             pop_idx = 0;
    int             gaps = 0;
    bit             prev_pop = 0;
    bit             stalled_prev = 0;
    logic [127:0]   held_data;
    logic           held_last;
    logic [LOGN-1:0] rd_addr_exp = '0;

    always @(negedge clk) begin
        wr_t          w;
        logic [128:0] r;
        bit           pop;
        if (rst) begin
            pop = bus.m_valid && bus.m_ready;
            if (bus.mem_en && bus.mem_we) begin
                if (wexp.size() == 0) check("write_unexpected", 1, 0);
                else begin
                    w = wexp.pop_front();
                    check("write_addr", bus.mem_addr, w.addr);
                    check("write_data", bus.mem_wdata, w.data);
                    check("write_grant", mem_grant, 0);
                end
            end
            if (stalled_prev) begin
                check("stall_valid", bus.m_valid, 1);
                check("stall_data", bus.m_data, held_data);
                check("stall_last", bus.m_last, held_last);
            end
            if (pop) begin
                pops++;
                if (pop_idx > 0 && !prev_pop) gaps++;
                if (rexp.size() == 0) check("result_unexpected", 1, 0);
                else begin
                    r = rexp.pop_front();
                    check("m_data", bus.m_data, r[127:0]);
                    check("m_last", bus.m_last, r[128]);
                end
                pop_idx = bus.m_last ? 0 : pop_idx + 1;
            end
            if (bus.mem_en && !bus.mem_we) begin
                reads_issued++;
                check("read_addr", bus.mem_addr, rd_addr_exp);
                check("reads_outstanding", (reads_issued - pops) <= 2, 1);
                rd_addr_exp = rd_addr_exp + 1'b1;
            end
            if (fft_start) n_start++;
            prev_pop     = pop;
            stalled_prev = bus.m_valid && !bus.m_ready;
            held_data    = bus.m_data;
            held_last    = bus.m_last;
        end
    end

    task automatic load_frame(input int base, input int n, input bit gap);
        for (int i = 0; i < n; i++) begin
            logic [DW-1:0]   d;
            logic [LOGN-1:0] idx;
            int              t;
            d   = $realtobits(real'(base + i));
            idx = i[LOGN-1:0];
            bus.s_data  = d;
            bus.s_valid = 1'b1;
            wexp.push_back(wr_t'{bitrev(idx), {d, 64'b0}});
            t = 0;
            @(negedge clk);
            while (!bus.s_ready && t < 50) begin
                @(negedge clk);
                t++;
            end
            if (t >= 50) check("s_ready_timeout", 0, 1);
            @(posedge clk);
            #1;
            if (gap) begin
                bus.s_valid = 1'b0;
                @(posedge clk);
                #1;
            end
        end
        bus.s_valid = 1'b0;
    endtask

    task automatic engine(input int seed, input int delay);
        repeat (delay) begin
            @(posedge clk);
            #1;
        end
        check("wait_grant", mem_grant, 1);
        eng_seed = seed;
        eng_fill = 1;
        @(posedge clk);
        #1;
        eng_fill = 0;
        for (int k = 0; k < N; k++)
            rexp.push_back({(k == N - 1) ? 1'b1 : 1'b0, 64'(seed + k), ~64'(seed + k)});
        fft_done = 1'b1;
        @(posedge clk);
        #1;
        fft_done = 1'b0;
    endtask

    task automatic wait_unload(input int exp_fc, input int budget);
        int t;
        t = 0;
        while (frame_cnt != FCW'(exp_fc) && t < budget) begin
            @(posedge clk);
            #1;
            t++;
        end
        check("frame_cnt", frame_cnt, exp_fc);
        check("results_drained", rexp.size(), 0);
        check("s_ready_after", bus.s_ready, 1);
        check("busy_after", busy, 0);
    endtask

    initial begin
        bus.s_valid = 1'b0;
        bus.s_data  = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_s_ready", bus.s_ready, 0);
        check("rst_busy", busy, 0);
        check("rst_grant", mem_grant, 0);
        check("rst_start", fft_start, 0);
        check("rst_m_valid", bus.m_valid, 0);
        check("rst_frame_cnt", frame_cnt, 0);
        rst = 1'b1;
        #1;
        check("release_s_ready", bus.s_ready, 0);
        @(posedge clk);
        #1;
        check("run_s_ready", bus.s_ready, 1);

        // bit-reversed load, start pulse, then natural-order unload at full rate
        load_frame(1, N, 0);
        check("start_pulse", fft_start, 1);
        check("start_s_ready", bus.s_ready, 0);
        check("start_grant", mem_grant, 1);
        @(posedge clk);
        #1;
        check("start_single", fft_start, 0);
        check("wait_grant_now", mem_grant, 1);
        gaps = 0;
        engine(0, 18);
        wait_unload(1, 100);
        check("full_rate_gaps", gaps, 0);

        // done pulses outside WAIT are ignored
        fft_done = 1'b1;
        @(posedge clk);
        #1;
        fft_done = 1'b0;
        check("done_in_load_busy", busy, 0);
        check("done_in_load_ready", bus.s_ready, 1);
        load_frame(40, N, 0);
        fft_done = 1'b1;
        @(posedge clk);
        #1;
        fft_done = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        check("still_wait_grant", mem_grant, 1);
        check("still_wait_valid", bus.m_valid, 0);
        check("still_wait_mem_en", bus.mem_en, 0);
        check("still_wait_busy", busy, 1);
        engine(100, 2);
        wait_unload(2, 100);

        // backpressured unload
        rdy_random = 1;
        load_frame(200, N, 0);
        engine(7, 4);
        wait_unload(3, 600);
        check("starts_before_reset", n_start, 3);

        // reset mid-frame
        load_frame(500, 5, 0);
        check("partial_busy", busy, 1);
        @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        check("mid_rst_s_ready", bus.s_ready, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_mem_en", bus.mem_en, 0);
        check("mid_rst_mem_we", bus.mem_we, 0);
        check("mid_rst_m_valid", bus.m_valid, 0);
        check("mid_rst_m_last", bus.m_last, 0);
        check("mid_rst_start", fft_start, 0);
        check("mid_rst_grant", mem_grant, 0);
        check("mid_rst_frame_cnt", frame_cnt, 0);
        check("mid_rst_writes", wexp.size(), 0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("no_start_after_rst", n_start, 3);

        // three back-to-back gapped frames
        for (int f = 0; f < 3; f++) begin
            rdy_random = (f == 1);
            load_frame(1000 + 16 * f, N, 1);
            engine(3000 + 50 * f, 3 + f);
            wait_unload(f + 1, 600);
        end
        check("total_starts", n_start, 6);
        check("writes_drained", wexp.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/fft_stream_loader.md
Name: fft_stream_loader

Overview:
Host-side partner of the fft engine on its shared sample RAM.
- Streams N real samples in through a valid/ready port and writes them to the RAM in bit-reversed address order, imaginary part zero.
- Hands RAM ownership to the fft engine, pulses its start, and waits for completion.
- Reads the N complex results in natural order and streams them out with valid/ready and a last marker.

Parameters:
LOGN, 12, log2 of transform length; N = 2**LOGN.
DW, 64, width of one IEEE-754 double component.
FCW, 16, width of the completed-frame counter.

Ports:
clk  in  1  single clock; all state changes on its rising edge.
rst  in  1  asynchronous, active-low reset.
s_data  in  DW  input real sample.
s_valid  in  1  input sample valid.
s_ready  out  1  loader accepts a sample this cycle.
m_data  out  2*DW  result word: real in [2*DW-1:DW], imaginary in [DW-1:0].
m_valid  out  1  result valid.
m_ready  in  1  downstream accepts a result.
m_last  out  1  high with the N-th result of a frame.
mem_en  out  1  RAM port enable (loader side).
mem_we  out  1  RAM write enable.
mem_addr  out  LOGN  RAM word address.
mem_wdata  out  2*DW  RAM write data.
mem_rdata  in  2*DW  RAM read data; valid exactly 1 cycle after mem_en with mem_we low.
mem_grant  out  1  0 = loader owns RAM, 1 = fft engine owns RAM.
fft_start  out  1  one-cycle start pulse to the engine.
fft_done  in  1  one-cycle completion pulse from the engine.
busy  out  1  high in every state other than LOAD with a zero count.
frame_cnt  out  FCW  number of frames fully unloaded; wraps modulo 2**FCW.

Behaviour:
Reset (rst low, asynchronous):
- state = LOAD; all counters 0.
- s_ready = 0 during reset, 1 from the first clock after release.
- m_valid, m_last, mem_en, mem_we, fft_start, mem_grant, busy = 0; frame_cnt = 0; output buffer emptied.
- Reset mid-frame discards the frame entirely; no fft_start is issued for it.

State LOAD:
- s_ready = 1, mem_grant = 0.
- On each s_valid & s_ready: mem_en = mem_we = 1, mem_addr = bitrev(wcnt), mem_wdata = {s_data, DW'b0}, wcnt increments. The write is combinational in the same cycle as the handshake.
- When the accepted sample is number N-1 (wcnt all ones): wcnt wraps to 0, next state = START.

State START (exactly 1 cycle):
- s_ready = 0, fft_start = 1, mem_grant = 1. Next state = WAIT.

State WAIT:
- mem_grant = 1, all mem_* outputs 0.
- fft_done is sampled only in this state; it is ignored in every other state. When it is seen, next state = UNLOAD and mem_grant drops to 0 on the same edge.

State UNLOAD:
- mem_grant = 0; natural-order reads at addr rcnt.
- A 2-entry output FIFO absorbs the 1-cycle RAM latency.
- A read issues (mem_en = 1, mem_we = 0) only when occupancy + reads in flight < 2, after accounting for a pop in the same cycle.
- m_data/m_valid/m_last stay stable while m_valid & ~m_ready.
- m_last is tagged on the entry read from address N-1.
- After the m_last handshake: frame_cnt increments, state = LOAD.
- With m_ready held high, sustained throughput is 1 word per cycle after the first-read latency.

Width and arithmetic:
- bitrev reverses all LOGN bits.
- Counters are LOGN bits wide and wrap silently.
- No arithmetic is performed on data.

Test Plan:
1. LOGN=3; push samples 1.0..8.0 with s_valid held high -> writes land at addresses 0,4,2,6,1,5,3,7 with imaginary part 0; s_ready falls after the 8th; fft_start is a single pulse the next cycle; mem_grant = 1.
2. LOGN=3; return fft_done 20 cycles after start, with a bench RAM model preloaded with word k = {k, ~k}; m_ready held high -> 8 results in natural order on consecutive cycles after the first-read latency; m_last only on the 8th; frame_cnt = 1; s_ready = 1 afterwards.
3. Unload with m_ready toggling pseudo-randomly (about 30% high) -> no lost, duplicated or reordered words; m_data stable while stalled; at most 2 reads outstanding.
4. fft_done pulsed during LOAD and during START -> ignored; the loader stays in WAIT until a fft_done arrives in WAIT.
5. Drop rst low after 5 of 8 samples are loaded -> all outputs are 0 immediately, without waiting for a clock edge; the next frame loads cleanly from address 0; frame_cnt = 0.
6. Run 3 back-to-back frames with s_valid gapped every other cycle -> 3 fft_start pulses; frame_cnt = 3; every frame's output matches the RAM model.
